// File: rtl/fpu_pkg.sv
// Shared types and constants for moving FPU memory operands over the 16-bit bus.
package fpu_pkg;

    localparam int FPU_WORD_W    = 16;
    localparam int FPU_OPND_W    = 80;
    localparam int FPU_MAX_WORDS = FPU_OPND_W / FPU_WORD_W;

    typedef enum logic [2:0] {
        SIZE_16 = 3'd0,
        SIZE_32 = 3'd1,
        SIZE_64 = 3'd2,
        SIZE_80 = 3'd3
    } fpu_size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_REQ,
        ST_GAP,
        ST_PUSH,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    // Encodings 4..7 are invalid and report zero words.
    function automatic logic [2:0] words_for_size(input logic [2:0] size);
        case (size)
            SIZE_16: return 3'd1;
            SIZE_32: return 3'd2;
            SIZE_64: return 3'd4;
            SIZE_80: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic size_valid(input logic [2:0] size);
        return !size[2];
    endfunction

endpackage

// File: rtl/fpu_operand_sequencer_if.sv
// Memory bus and FPU data port seen by the operand sequencer (master side).
interface fpu_operand_sequencer_if #(
    parameter int ADDR_W = 20
);
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_data_out;
    logic [15:0]       mem_data_in;
    logic              mem_access;
    logic              mem_wr_en;
    logic [1:0]        mem_bytesel;
    logic              mem_ack;
    logic              fpu_data_write;
    logic              fpu_data_read;
    logic [2:0]        fpu_data_size;
    logic [79:0]       fpu_data_in;
    logic [79:0]       fpu_data_out;
    logic              fpu_data_ready;

    modport master (
        output mem_address, mem_data_out, mem_access, mem_wr_en, mem_bytesel,
        input  mem_data_in, mem_ack,
        output fpu_data_write, fpu_data_read, fpu_data_size, fpu_data_in,
        input  fpu_data_out, fpu_data_ready
    );

    modport slave (
        input  mem_address, mem_data_out, mem_access, mem_wr_en, mem_bytesel,
        output mem_data_in, mem_ack,
        input  fpu_data_write, fpu_data_read, fpu_data_size, fpu_data_in,
        output fpu_data_out, fpu_data_ready
    );
endinterface

// File: rtl/fpu_operand_sequencer.sv
// Bursts 1/2/4/5 memory words into the FPU (load) or out of it (store).
module fpu_operand_sequencer
    import fpu_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  dir,
    input  logic [2:0]            size,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    fpu_operand_sequencer_if.master bus
);

    localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    seq_state_t        state_reg, state_next;
    logic              dir_reg;
    logic [2:0]        size_reg;
    logic [2:0]        nwords_reg;
    logic [2:0]        idx_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic              abort_pend_reg;
    logic [FPU_WORD_W-1:0] buf_reg [FPU_MAX_WORDS];
    logic [FPU_OPND_W-1:0] buf_flat;
    logic [FPU_OPND_W-1:0] push_hold_reg;

    logic accept, fetch_hit, req_ack, more_words, push_fire;

    assign accept     = (state_reg == ST_IDLE) && start;
    assign fetch_hit  = (state_reg == ST_FETCH) && bus.fpu_data_ready;
    assign req_ack    = (state_reg == ST_REQ) && bus.mem_ack;
    assign more_words = (idx_reg + 3'd1) < nwords_reg;
    assign push_fire  = (state_reg == ST_PUSH) && !abort;

    // One register per bus word; the buffer is cleared on start so unused upper words read as zero.
    for (genvar gi = 0; gi < FPU_MAX_WORDS; gi++) begin : g_word
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                buf_reg[gi] <= '0;
            end else if (accept) begin
                buf_reg[gi] <= '0;
            end else if (fetch_hit) begin
                buf_reg[gi] <= bus.fpu_data_out[gi*FPU_WORD_W +: FPU_WORD_W];
            end else if (req_ack && !dir_reg && (idx_reg == 3'(gi))) begin
                buf_reg[gi] <= bus.mem_data_in;
            end
        end
        assign buf_flat[gi*FPU_WORD_W +: FPU_WORD_W] = buf_reg[gi];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_reg        <= 1'b0;
            size_reg       <= '0;
            nwords_reg     <= '0;
            idx_reg        <= '0;
            base_reg       <= '0;
            to_cnt_reg     <= '0;
            abort_pend_reg <= 1'b0;
            push_hold_reg  <= '0;
        end else begin
            if (accept) begin
                dir_reg        <= dir;
                size_reg       <= size;
                nwords_reg     <= words_for_size(size);
                base_reg       <= base_addr;
                idx_reg        <= '0;
                to_cnt_reg     <= '0;
                abort_pend_reg <= 1'b0;
            end
            if ((state_reg == ST_FETCH) && !bus.fpu_data_ready) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            // An abort during a bus cycle waits for the ack so the cycle is never cut short.
            if ((state_reg == ST_REQ) && abort) begin
                abort_pend_reg <= 1'b1;
            end
            if (req_ack) begin
                idx_reg <= idx_reg + 3'd1;
            end
            if (push_fire) begin
                push_hold_reg <= buf_flat;
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        busy               = 1'b1;
        done               = 1'b0;
        error              = 1'b0;
        bus.mem_access     = 1'b0;
        bus.mem_wr_en      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_data_out   = '0;
        bus.fpu_data_read  = 1'b0;
        bus.fpu_data_write = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (!size_valid(size)) state_next = ST_ERR;
                    else if (dir)          state_next = ST_FETCH;
                    else                   state_next = ST_REQ;
                end
            end
            ST_FETCH: begin
                bus.fpu_data_read = 1'b1;
                if (abort)                                state_next = ST_IDLE;
                else if (bus.fpu_data_ready)              state_next = ST_REQ;
                else if (to_cnt_reg == TO_W'(TIMEOUT))    state_next = ST_ERR;
            end
            ST_REQ: begin
                bus.mem_access   = 1'b1;
                bus.mem_wr_en    = dir_reg;
                bus.mem_address  = base_reg + (ADDR_W'(idx_reg) << 1);
                bus.mem_data_out = buf_reg[idx_reg];
                if (bus.mem_ack) begin
                    if (abort_pend_reg || abort) state_next = ST_IDLE;
                    else if (more_words)         state_next = ST_GAP;
                    else if (dir_reg)            state_next = ST_DONE;
                    else                         state_next = ST_PUSH;
                end
            end
            ST_GAP: begin
                state_next = abort ? ST_IDLE : ST_REQ;
            end
            ST_PUSH: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    bus.fpu_data_write = 1'b1;
                    state_next         = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                error      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.mem_bytesel   = 2'b00;
    assign bus.fpu_data_size = size_reg;
    assign bus.fpu_data_in   = push_fire ? buf_flat : push_hold_reg;

endmodule
